// File: rtl/mips_alu_seq_pkg.sv
// Purpose : shared op codes, FSM states and helpers for the MIPS EX-stage ALU
//           and the control unit that drives it.
// Contents: OP_W, alu_op_e, state_e, is_multi_op().
package mips_alu_seq_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      ALU_AND   = 4'd0,
      ALU_OR    = 4'd1,
      ALU_ADD   = 4'd2,
      ALU_XOR   = 4'd3,
      ALU_NOR   = 4'd4,
      ALU_SLTU  = 4'd5,
      ALU_SUB   = 4'd6,
      ALU_SLT   = 4'd7,
      ALU_MFHI  = 4'd8,
      ALU_MFLO  = 4'd9,
      ALU_MULTU = 4'd12,
      ALU_DIVU  = 4'd13
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_e;

   // Ops that run through the iterative HI/LO engine
   function automatic logic is_multi_op(input logic [OP_W-1:0] op);
      return (op == ALU_MULTU) || (op == ALU_DIVU);
   endfunction

endpackage

// File: rtl/mips_alu_seq_if.sv
// Purpose : request/response bundle between EX-stage control and the ALU.
// Signals : start/op/a/b (request, master -> slave);
//           result/zero/overflow/done/busy/hi/lo (response, slave -> master).
interface mips_alu_seq_if
   import mips_alu_seq_pkg::*;
#(
   parameter int unsigned ALU_WIDTH = 8
) ();

   logic                 start;
   logic [OP_W-1:0]      op;
   logic [ALU_WIDTH-1:0] a;
   logic [ALU_WIDTH-1:0] b;
   logic [ALU_WIDTH-1:0] result;
   logic                 zero;
   logic                 overflow;
   logic                 done;
   logic                 busy;
   logic [ALU_WIDTH-1:0] hi;
   logic [ALU_WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  result, zero, overflow, done, busy, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output result, zero, overflow, done, busy, hi, lo
   );

endinterface

// File: rtl/mips_muldiv_iter.sv
// Purpose : one combinational step of the iterative multiply/divide engine.
// Ports   : div   - 0: shift-add multiply step, 1: restoring divide step
//           hi_in - partial product upper half / partial remainder
//           lo_in - multiplier being consumed / dividend being shifted out
//           opnd  - multiplicand / divisor
//           hi_c, lo_c - next hi/lo working values
module mips_muldiv_iter #(
   parameter int unsigned W = 8
) (
   input  logic         div,
   input  logic [W-1:0] hi_in,
   input  logic [W-1:0] lo_in,
   input  logic [W-1:0] opnd,
   output logic [W-1:0] hi_c,
   output logic [W-1:0] lo_c
);

   logic [W:0]   sum;
   logic [W:0]   shifted;
   logic [W-1:0] diff;
   logic         ge;

   always_comb begin
      // Multiply: conditionally add multiplicand, then shift {carry,hi,lo} right
      sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : '0);
      // Divide: shift next dividend bit into the remainder, trial subtract
      shifted = {hi_in, lo_in[W-1]};
      ge      = (shifted >= {1'b0, opnd});
      // Remainder stays below the divisor, so W bits of the difference suffice
      diff    = shifted[W-1:0] - opnd;

      if (div) begin
         hi_c = ge ? diff : shifted[W-1:0];
         lo_c = {lo_in[W-2:0], ge};
      end else begin
         hi_c = sum[W:1];
         lo_c = {sum[0], lo_in[W-1:1]};
      end
   end

endmodule

// File: rtl/mips_alu_seq.sv
// Purpose : EX-stage ALU with registered single-cycle ops and an iterative
//           unsigned multiply/divide engine writing HI/LO.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - mips_alu_seq_if slave (start/op/a/b in;
//                   result/zero/overflow/done/busy/hi/lo out)
module mips_alu_seq
   import mips_alu_seq_pkg::*;
#(
   parameter int unsigned ALU_WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   mips_alu_seq_if.slave  bus
);

   localparam int unsigned W     = ALU_WIDTH;
   localparam int unsigned CNT_W = $clog2(W) + 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     wk_hi_q, wk_lo_q, opnd_q;
   logic [W-1:0]     step_hi_c, step_lo_c;
   logic [W-1:0]     result_q, hi_q, lo_q;
   logic             zero_q, overflow_q, done_q, busy_q;

   logic             accept_c;
   logic             last_step_c;
   logic [W-1:0]     sum_c, diff_c, alu_res_c;
   logic             alu_ovf_c;

   mips_muldiv_iter #(.W(W)) u_iter (
      .div   (state_q == ST_DIV),
      .hi_in (wk_hi_q),
      .lo_in (wk_lo_q),
      .opnd  (opnd_q),
      .hi_c  (step_hi_c),
      .lo_c  (step_lo_c)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state and handshake strobes; requests are dropped unless idle
   always_comb begin
      state_d     = state_q;
      accept_c    = 1'b0;
      last_step_c = (cnt_q == CNT_W'(W - 1));
      case (state_q)
         ST_IDLE: begin
            accept_c = bus.start;
            if (bus.start && (bus.op == ALU_MULTU)) state_d = ST_MUL;
            if (bus.start && (bus.op == ALU_DIVU))  state_d = ST_DIV;
         end
         ST_MUL, ST_DIV: begin
            if (last_step_c) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Single-cycle result and signed-overflow logic
   always_comb begin
      sum_c     = bus.a + bus.b;
      diff_c    = bus.a - bus.b;
      alu_res_c = '0;
      alu_ovf_c = 1'b0;
      case (bus.op)
         ALU_AND:  alu_res_c = bus.a & bus.b;
         ALU_OR:   alu_res_c = bus.a | bus.b;
         ALU_XOR:  alu_res_c = bus.a ^ bus.b;
         ALU_NOR:  alu_res_c = ~(bus.a | bus.b);
         ALU_ADD: begin
            alu_res_c = sum_c;
            alu_ovf_c = (bus.a[W-1] == bus.b[W-1]) && (sum_c[W-1] != bus.a[W-1]);
         end
         ALU_SUB: begin
            alu_res_c = diff_c;
            alu_ovf_c = (bus.a[W-1] != bus.b[W-1]) && (diff_c[W-1] != bus.a[W-1]);
         end
         ALU_SLTU: alu_res_c = W'(bus.a < bus.b);
         ALU_SLT:  alu_res_c = W'($signed(bus.a) < $signed(bus.b));
         ALU_MFHI: alu_res_c = hi_q;
         ALU_MFLO: alu_res_c = lo_q;
         default:  alu_res_c = '0;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         wk_hi_q    <= '0;
         wk_lo_q    <= '0;
         opnd_q     <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept_c) begin
            if (is_multi_op(bus.op)) begin
               // Same operand layout serves both engines: lo holds a, opnd holds b
               busy_q  <= 1'b1;
               cnt_q   <= '0;
               wk_hi_q <= '0;
               wk_lo_q <= bus.a;
               opnd_q  <= bus.b;
            end else begin
               result_q   <= alu_res_c;
               zero_q     <= (alu_res_c == '0);
               overflow_q <= alu_ovf_c;
               done_q     <= 1'b1;
            end
         end
         if (state_q != ST_IDLE) begin
            wk_hi_q <= step_hi_c;
            wk_lo_q <= step_lo_c;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_step_c) begin
               hi_q   <= step_hi_c;
               lo_q   <= step_lo_c;
               done_q <= 1'b1;
               busy_q <= 1'b0;
            end
         end
      end
   end

   assign bus.result   = result_q;
   assign bus.zero     = zero_q;
   assign bus.overflow = overflow_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mips_alu_seq.sv
// Purpose : self-checking bench for mips_alu_seq (ALU_WIDTH=8): directed and
//           random requests, scoreboard of expected responses popped on done.
module tb_mips_alu_seq;
   import mips_alu_seq_pkg::*;

   localparam int unsigned W = 8;
   localparam logic [W-1:0] ALL_ONES = '1;

   logic clk;
   logic reset;

   mips_alu_seq_if #(.ALU_WIDTH(W)) bus ();

   mips_alu_seq #(.ALU_WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic         zero;
      logic         ovf;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Architectural view of the ALU state
   logic [W-1:0] m_res, m_hi, m_lo;
   logic         m_zero, m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_res = '0; m_zero = 1'b0; m_ovf = 1'b0; m_hi = '0; m_lo = '0;
   endtask

   // Apply one accepted request to the model and queue the expected response
   task automatic model_apply(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sbv, s;
      int unsigned p;
      logic [W-1:0] r;
      logic o;
      logic multi;
      exp_t e;
      sa = $signed(a);
      sbv = $signed(b);
      r = '0; o = 1'b0; multi = 1'b0;
      case (op)
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_NOR:  r = ~(a | b);
         ALU_ADD: begin
            s = sa + sbv; r = W'(s);
            o = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
         end
         ALU_SUB: begin
            s = sa - sbv; r = W'(s);
            o = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
         end
         ALU_SLTU: r = (int'(a) < int'(b)) ? W'(1) : W'(0);
         ALU_SLT:  r = (sa < sbv) ? W'(1) : W'(0);
         ALU_MFHI: r = m_hi;
         ALU_MFLO: r = m_lo;
         ALU_MULTU: begin
            multi = 1'b1;
            p = 32'(a) * 32'(b);
            m_hi = W'(p >> W);
            m_lo = W'(p);
         end
         ALU_DIVU: begin
            multi = 1'b1;
            if (b == 0) begin
               m_lo = ALL_ONES; m_hi = a;
            end else begin
               m_lo = a / b; m_hi = a % b;
            end
         end
         default: r = '0;
      endcase
      if (!multi) begin
         m_res = r; m_zero = (r == 0); m_ovf = o;
      end
      e.res = m_res; e.zero = m_zero; e.ovf = m_ovf; e.hi = m_hi; e.lo = m_lo;
      sb.push_back(e);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
         end else begin
            e = sb.pop_front();
            check("result",   bus.result,   e.res);
            check("zero",     bus.zero,     e.zero);
            check("overflow", bus.overflow, e.ovf);
            check("hi",       bus.hi,       e.hi);
            check("lo",       bus.lo,       e.lo);
         end
      end
   end

   // Issue one request from a negedge; returns at the negedge where done is due.
   // inject_at > 0 pulses a spurious ADD request in that busy cycle.
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject_at);
      int n;
      check("idle_before_start", bus.busy, 0);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      model_apply(op, a, b);
      @(negedge clk);
      bus.start = 1'b0;
      if (op == ALU_MULTU || op == ALU_DIVU) begin
         n = 0;
         while (bus.busy === 1'b1 && n < 4 * W) begin
            n++;
            if (n == inject_at) begin
               bus.start = 1'b1; bus.op = ALU_ADD;
               bus.a = W'($urandom); bus.b = W'($urandom);
            end else begin
               bus.start = 1'b0;
            end
            @(negedge clk);
         end
         bus.start = 1'b0;
         check("busy_cycles", n, W);
         check("multi_done", bus.done, 1);
      end else begin
         check("single_done", bus.done, 1);
         check("single_busy", bus.busy, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected end of run");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] rop;
      reset = 1'b1;
      bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_result",   bus.result,   0);
      check("rst_zero",     bus.zero,     0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_done",     bus.done,     0);
      check("rst_busy",     bus.busy,     0);
      check("rst_hi",       bus.hi,       0);
      check("rst_lo",       bus.lo,       0);
      reset = 1'b0;
      @(negedge clk);

      // Directed cases
      do_op(ALU_ADD, 8'h7F, 8'h01, -1);
      check("add_const_result", bus.result, 8'h80);
      check("add_const_ovf", bus.overflow, 1);
      do_op(ALU_SUB, 8'h05, 8'h05, -1);
      check("sub_const_zero", bus.zero, 1);
      do_op(ALU_SLT, 8'hFF, 8'h01, -1);
      check("slt_const", bus.result, 1);
      do_op(ALU_SLTU, 8'hFF, 8'h01, -1);
      check("sltu_const", bus.result, 0);
      do_op(4'd10, 8'h33, 8'h44, -1);
      do_op(ALU_MULTU, 8'hFF, 8'hFF, -1);
      check("mul_const_hi", bus.hi, 8'hFE);
      check("mul_const_lo", bus.lo, 8'h01);
      do_op(ALU_MFHI, 8'h00, 8'h00, -1);
      check("mfhi_const", bus.result, 8'hFE);
      do_op(ALU_DIVU, 8'd100, 8'd7, -1);
      check("div_const_lo", bus.lo, 8'd14);
      check("div_const_hi", bus.hi, 8'd2);
      do_op(ALU_MFLO, 8'h00, 8'h00, -1);
      do_op(ALU_DIVU, 8'h2A, 8'h00, -1);
      check("div0_const_lo", bus.lo, 8'hFF);
      check("div0_const_hi", bus.hi, 8'h2A);
      do_op(ALU_ADD, 8'h10, 8'h20, -1);
      do_op(ALU_MULTU, 8'h12, 8'h34, 3);
      check("mul_inject_result", bus.result, 8'h30);

      // Reset in the middle of a divide
      bus.start = 1'b1; bus.op = ALU_DIVU; bus.a = 8'hC8; bus.b = 8'h03;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_busy",   bus.busy,   0);
      check("abort_done",   bus.done,   0);
      check("abort_hi",     bus.hi,     0);
      check("abort_lo",     bus.lo,     0);
      check("abort_result", bus.result, 0);
      sb.delete();
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_op(ALU_MULTU, 8'h0B, 8'h0D, -1);
      do_op(ALU_MFLO, 8'h00, 8'h00, -1);

      // Random traffic, back-to-back with occasional gaps and spurious starts
      for (int i = 0; i < 200; i++) begin
         rop = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) rop = ($urandom_range(0, 1) == 1) ? ALU_MULTU : ALU_DIVU;
         do_op(rop, W'($urandom), W'($urandom),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W)) : -1);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
